slurm16_interrupt_controller: RTL and testbench

- Port-mapped interrupt controller directly upstream of the SLURM16 CPU top.
- Edge-detects 16 synchronous interrupt sources, latches them into a pending register and masks them with a software enable register.
- Priority-encodes the highest-priority request onto the CPU `interrupt`/`irq[3:0]` inputs.
- Software accesses the controller over the CPU port bus: read enable/pending/status, clear pending (write-1-to-clear), force software interrupts.

---
 rtl/slurm16_interrupt_controller.sv | 100 ++++++++++
 tb/tb_slurm16_interrupt_controller.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/slurm16_interrupt_controller.sv
// Port-mapped interrupt controller for the SLURM16 CPU: edge-detects 16 sources into a
// W1C pending register, masks them with an enable register and priority-encodes onto irq.
module slurm16_interrupt_controller #(
    parameter logic [3:0]  ADDRESS_BASE = 4'h7,
    parameter int unsigned BITS         = 16
) (
    input  logic            CLK,
    input  logic            RSTb,
    input  logic [15:0]     port_address,
    input  logic [BITS-1:0] port_in,
    output logic [BITS-1:0] port_out,
    input  logic            port_rd,
    input  logic            port_wr,
    input  logic [BITS-1:0] irq_sources,
    output logic            interrupt,
    output logic [3:0]      irq
);

    localparam int unsigned IDX_W = 4;

    localparam logic [1:0] REG_ENABLE  = 2'd0;
    localparam logic [1:0] REG_PENDING = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_FORCE   = 2'd3;

    logic [BITS-1:0]  enable_q, enable_d;
    logic [BITS-1:0]  pending_q, pending_d;
    logic [BITS-1:0]  src_q;
    logic [BITS-1:0]  port_out_q, port_out_d;
    logic             interrupt_q, interrupt_d;
    logic [IDX_W-1:0] irq_q, irq_d;

    logic             sel;
    logic [1:0]       addr;
    logic [BITS-1:0]  set_edge, clr, force_set, req, rd_data;
    logic             unused_addr;

    assign unused_addr = ^port_address[11:2];

    // Register writes, pending update and read-data mux
    always_comb begin
        sel       = (port_address[15:12] == ADDRESS_BASE);
        addr      = port_address[1:0];
        set_edge  = irq_sources & ~src_q;
        clr       = '0;
        force_set = '0;
        enable_d  = enable_q;
        if (sel && port_wr) begin
            case (addr)
                REG_ENABLE:  enable_d  = port_in;
                REG_PENDING: clr       = port_in;
                REG_FORCE:   force_set = port_in;
                default:     ;
            endcase
        end
        // Sets are OR'd in after the clear so a same-cycle set wins
        pending_d = (pending_q & ~clr) | set_edge | force_set;

        case (addr)
            REG_ENABLE:  rd_data = enable_q;
            REG_PENDING: rd_data = pending_q;
            REG_STATUS:  rd_data = BITS'({interrupt_q, irq_q});
            default:     rd_data = '0;
        endcase
        port_out_d = (sel && port_rd) ? rd_data : port_out_q;
    end

    // Priority encoder: lowest set bit of the masked request wins
    always_comb begin
        req         = pending_q & enable_q;
        interrupt_d = |req;
        irq_d       = '0;
        for (int i = BITS - 1; i >= 0; i--) begin
            if (req[i]) irq_d = IDX_W'(i);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            enable_q    <= '0;
            pending_q   <= '0;
            src_q       <= '0;
            port_out_q  <= '0;
            interrupt_q <= 1'b0;
            irq_q       <= '0;
        end else begin
            enable_q    <= enable_d;
            pending_q   <= pending_d;
            src_q       <= irq_sources;
            port_out_q  <= port_out_d;
            interrupt_q <= interrupt_d;
            irq_q       <= irq_d;
        end
    end

    assign port_out  = port_out_q;
    assign interrupt = interrupt_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_slurm16_interrupt_controller.sv
// Table-driven bench for slurm16_interrupt_controller; each row's expected outputs are
// queued when the row is driven and checked just after the following clock edge.
module tb_slurm16_interrupt_controller;

    logic        CLK = 1'b0;
    logic        RSTb;
    logic [15:0] port_address;
    logic [15:0] port_in;
    logic [15:0] port_out;
    logic        port_rd;
    logic        port_wr;
    logic [15:0] irq_sources;
    logic        interrupt;
    logic [3:0]  irq;

    slurm16_interrupt_controller dut (
        .CLK          (CLK),
        .RSTb         (RSTb),
        .port_address (port_address),
        .port_in      (port_in),
        .port_out     (port_out),
        .port_rd      (port_rd),
        .port_wr      (port_wr),
        .irq_sources  (irq_sources),
        .interrupt    (interrupt),
        .irq          (irq)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic        rstn;
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic [15:0] src;
        logic        e_int;
        logic [3:0]  e_irq;
        logic [15:0] e_out;
    } vec_t;

    localparam logic [15:0] A_EN  = 16'h7000;
    localparam logic [15:0] A_PND = 16'h7001;
    localparam logic [15:0] A_ST  = 16'h7002;
    localparam logic [15:0] A_FRC = 16'h7003;

    vec_t tbl[$];
    vec_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(string name, logic rstn, logic rd, logic wr, logic [15:0] addr,
                                logic [15:0] din, logic [15:0] src, logic e_int,
                                logic [3:0] e_irq, logic [15:0] e_out);
        vec_t v;
        v.name = name; v.rstn = rstn; v.rd = rd; v.wr = wr; v.addr = addr; v.din = din;
        v.src = src; v.e_int = e_int; v.e_irq = e_irq; v.e_out = e_out;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        vec_t e;
        RSTb         = v.rstn;
        port_rd      = v.rd;
        port_wr      = v.wr;
        port_address = v.addr;
        port_in      = v.din;
        irq_sources  = v.src;
        sb.push_back(v);
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        total++;
        if (interrupt !== e.e_int) begin
            bad++;
            $display("FAIL %s interrupt got=%0b want=%0b", e.name, interrupt, e.e_int);
        end
        total++;
        if (irq !== e.e_irq) begin
            bad++;
            $display("FAIL %s irq got=%0d want=%0d", e.name, irq, e.e_irq);
        end
        total++;
        if (port_out !== e.e_out) begin
            bad++;
            $display("FAIL %s port_out got=%h want=%h", e.name, port_out, e.e_out);
        end
    endtask

    initial begin
        //                  name       rstn rd wr addr       din       src       int irq  out
        tbl.push_back(mk("rst_wr",     0, 1, 1, A_EN,  16'hFFFF, 16'hFFFF, 0, 0, 16'h0000));
        tbl.push_back(mk("rst_hold",   0, 0, 0, A_EN,  16'h0000, 16'hFFFF, 0, 0, 16'h0000));
        tbl.push_back(mk("rel_edge",   1, 0, 0, A_EN,  16'h0000, 16'hFFFF, 0, 0, 16'h0000));
        tbl.push_back(mk("rd_pnd_all", 1, 1, 0, A_PND, 16'h0000, 16'hFFFF, 0, 0, 16'hFFFF));
        tbl.push_back(mk("w1c_all",    1, 0, 1, A_PND, 16'hFFFF, 16'h0000, 0, 0, 16'hFFFF));
        tbl.push_back(mk("rdwr_en",    1, 1, 1, A_EN,  16'h0030, 16'h0000, 0, 0, 16'h0000));
        tbl.push_back(mk("src54",      1, 0, 0, A_EN,  16'h0000, 16'h0030, 0, 0, 16'h0000));
        tbl.push_back(mk("irq4",       1, 0, 0, A_EN,  16'h0000, 16'h0000, 1, 4, 16'h0000));
        tbl.push_back(mk("w1c_b4",     1, 0, 1, A_PND, 16'h0010, 16'h0000, 1, 4, 16'h0000));
        tbl.push_back(mk("irq5",       1, 0, 0, A_EN,  16'h0000, 16'h0000, 1, 5, 16'h0000));
        tbl.push_back(mk("w1c_b5",     1, 0, 1, A_PND, 16'h0020, 16'h0000, 1, 5, 16'h0000));
        tbl.push_back(mk("idle0",      1, 0, 0, A_EN,  16'h0000, 16'h0000, 0, 0, 16'h0000));
        tbl.push_back(mk("en_b7",      1, 0, 1, A_EN,  16'h0080, 16'h0000, 0, 0, 16'h0000));
        tbl.push_back(mk("set_vs_clr", 1, 0, 1, A_PND, 16'h0080, 16'h0080, 0, 0, 16'h0000));
        tbl.push_back(mk("irq7",       1, 0, 0, A_EN,  16'h0000, 16'h0000, 1, 7, 16'h0000));
        tbl.push_back(mk("rd_pnd7",    1, 1, 0, A_PND, 16'h0000, 16'h0000, 1, 7, 16'h0080));
        tbl.push_back(mk("w1c_b7",     1, 0, 1, A_PND, 16'h0080, 16'h0000, 1, 7, 16'h0080));
        tbl.push_back(mk("idle7",      1, 0, 0, A_EN,  16'h0000, 16'h0000, 0, 0, 16'h0080));
        tbl.push_back(mk("en_off",     1, 0, 1, A_EN,  16'h0000, 16'h0000, 0, 0, 16'h0080));
        tbl.push_back(mk("src9_masked",1, 0, 0, A_EN,  16'h0000, 16'h0200, 0, 0, 16'h0080));
        tbl.push_back(mk("rd_pnd9",    1, 1, 0, A_PND, 16'h0000, 16'h0000, 0, 0, 16'h0200));
        tbl.push_back(mk("masked_idle",1, 0, 0, A_EN,  16'h0000, 16'h0000, 0, 0, 16'h0200));
        tbl.push_back(mk("en_b9",      1, 0, 1, A_EN,  16'h0200, 16'h0000, 0, 0, 16'h0200));
        tbl.push_back(mk("irq9",       1, 0, 0, A_EN,  16'h0000, 16'h0000, 1, 9, 16'h0200));
        tbl.push_back(mk("w1c_b9",     1, 0, 1, A_PND, 16'h0200, 16'h0000, 1, 9, 16'h0200));
        tbl.push_back(mk("idle9",      1, 0, 0, A_EN,  16'h0000, 16'h0000, 0, 0, 16'h0200));
        tbl.push_back(mk("en_all",     1, 0, 1, A_EN,  16'hFFFF, 16'h0000, 0, 0, 16'h0200));
        tbl.push_back(mk("force15",    1, 0, 1, A_FRC, 16'h8000, 16'h0000, 0, 0, 16'h0200));
        tbl.push_back(mk("irq15",      1, 0, 0, A_EN,  16'h0000, 16'h0000, 1, 15, 16'h0200));
        tbl.push_back(mk("other_page", 1, 1, 1, 16'h8001, 16'hFFFF, 16'h0000, 1, 15, 16'h0200));
        tbl.push_back(mk("rd_status",  1, 1, 0, A_ST,  16'h0000, 16'h0000, 1, 15, 16'h001F));
        tbl.push_back(mk("rd_force",   1, 1, 0, A_FRC, 16'h0000, 16'h0000, 1, 15, 16'h0000));
        tbl.push_back(mk("wr_status",  1, 0, 1, A_ST,  16'hFFFF, 16'h0000, 1, 15, 16'h0000));
        tbl.push_back(mk("force_b0",   1, 0, 1, A_FRC, 16'h0101, 16'h0000, 1, 15, 16'h0000));
        tbl.push_back(mk("irq0_top",   1, 0, 0, A_EN,  16'h0000, 16'h0000, 1, 0, 16'h0000));
        tbl.push_back(mk("w1c_all2",   1, 0, 1, A_PND, 16'hFFFF, 16'h0000, 1, 0, 16'h0000));
        tbl.push_back(mk("idle_clr",   1, 0, 0, A_EN,  16'h0000, 16'h0000, 0, 0, 16'h0000));
        tbl.push_back(mk("rd_en_all",  1, 1, 0, A_EN,  16'h0000, 16'h0000, 0, 0, 16'hFFFF));
        tbl.push_back(mk("force_b2",   1, 0, 1, A_FRC, 16'h0004, 16'h0000, 0, 0, 16'hFFFF));
        tbl.push_back(mk("irq2",       1, 0, 0, A_EN,  16'h0000, 16'h0000, 1, 2, 16'hFFFF));
        tbl.push_back(mk("mid_reset",  0, 1, 0, A_PND, 16'h0000, 16'h0000, 0, 0, 16'h0000));
        tbl.push_back(mk("post_reset", 1, 0, 0, A_EN,  16'h0000, 16'h0000, 0, 0, 16'h0000));
        tbl.push_back(mk("rd_en_rst",  1, 1, 0, A_EN,  16'h0000, 16'h0000, 0, 0, 16'h0000));

        foreach (tbl[i]) apply(tbl[i]);

        // Level held on source 3 for ten cycles, cleared at cycle 5: no retrigger
        apply(mk("lvl_en3", 1, 0, 1, A_EN, 16'h0008, 16'h0000, 0, 0, 16'h0000));
        for (int c = 0; c < 10; c++) begin
            logic act;
            act = (c >= 1) && (c <= 5);
            apply(mk($sformatf("lvl_c%0d", c), 1, 0, (c == 5), (c == 5) ? A_PND : A_EN,
                     (c == 5) ? 16'h0008 : 16'h0000, 16'h0008, act, act ? 4'd3 : 4'd0,
                     16'h0000));
        end
        apply(mk("lvl_rd_pnd", 1, 1, 0, A_PND, 16'h0000, 16'h0008, 0, 0, 16'h0000));
        apply(mk("lvl_drop",   1, 0, 0, A_EN,  16'h0000, 16'h0000, 0, 0, 16'h0000));

        // A fresh rising edge after the drop does set pending again
        apply(mk("lvl_rearm",  1, 0, 0, A_EN,  16'h0000, 16'h0008, 0, 0, 16'h0000));
        apply(mk("lvl_irq3",   1, 1, 0, A_PND, 16'h0000, 16'h0008, 1, 3, 16'h0008));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
